// File: rtl/pieo_sched_pkg.sv
// Shared types and helpers for the PIEO enqueue/dequeue scheduling blocks.
package pieo_sched_pkg;

  localparam int ID_LOG_DEF   = 2;
  localparam int RANK_LOG_DEF = 1;
  localparam int TIME_LOG_DEF = 1;
  localparam int ELEM_W       = ID_LOG_DEF + RANK_LOG_DEF + TIME_LOG_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  // Round-robin successor of cur among n slots.
  function automatic int rr_wrap_inc(input int cur, input int n);
    return ((cur + 32'sd1) >= n) ? 32'sd0 : (cur + 32'sd1);
  endfunction

endpackage

// File: rtl/pieo_rr_arbiter.sv
// Combinational round-robin pick: first request at or above i_ptr, wrapping.
module pieo_rr_arbiter
  import pieo_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_grant_valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]      w_off;
  logic                 w_found;
  logic [ID_W:0]        w_sum;
  logic [ID_W:0]        w_wrap;

  assign w_dbl = {i_req, i_req};
  // Rotating the doubled vector puts the request at i_ptr in bit 0.
  assign w_rot = w_dbl >> i_ptr;

  // Lowest set bit of the rotated vector is the offset from the pointer.
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_off   = w_rot[k] ? ID_W'(k) : w_off;
      w_found = w_found | w_rot[k];
    end
  end

  // Pointer plus offset, folded back into the 0..NUM_REQ-1 range.
  always_comb begin
    w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
    w_wrap = (w_sum >= (ID_W+1)'(NUM_REQ)) ? (w_sum - (ID_W+1)'(NUM_REQ)) : w_sum;
  end

  assign o_grant_id    = w_wrap[ID_W-1:0];
  assign o_grant_valid = w_found;

endmodule

// File: rtl/pieo_enq_scheduler.sv
// Feeds one PIEO element per FIFO into the PIEO, round-robin among eligible
// FIFOs, and tracks which FIFOs currently have an element inside the PIEO.
module pieo_enq_scheduler
  import pieo_sched_pkg::*;
#(
  parameter int NUM_FIFO  = 3,
  parameter int ID_LOG    = 2,
  parameter int RANK_LOG  = 1,
  parameter int TIME_LOG  = 1,
  parameter int SEND_TIME = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_FIFO-1:0]                 i_fifo_nonempty,
  input  logic [NUM_FIFO*RANK_LOG-1:0]        i_fifo_priority,
  input  logic                                i_pieo_ready_for_enq,
  input  logic                                i_pieo_deq_valid,
  input  logic [ID_LOG-1:0]                   i_pieo_deq_fifo_id,
  output logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] o_pieo_enq_element,
  output logic                                o_pieo_enq_trigger,
  output logic [NUM_FIFO-1:0]                 o_in_pieo,
  output logic                                o_deq_err
);

  localparam int EW = ID_LOG + RANK_LOG + TIME_LOG;

  sched_state_t          r_state;
  logic                  r_trig;
  logic [EW-1:0]         r_elem;
  logic [ID_LOG-1:0]     r_gid;
  logic [ID_LOG-1:0]     r_rr_ptr;
  logic [NUM_FIFO-1:0]   r_in_pieo;
  logic                  r_deq_err;

  sched_state_t          w_state_nxt;
  logic                  w_trig_nxt;
  logic [EW-1:0]         w_elem_nxt;
  logic [ID_LOG-1:0]     w_gid_nxt;
  logic [ID_LOG-1:0]     w_ptr_nxt;
  logic [NUM_FIFO-1:0]   w_elig;
  logic [ID_LOG-1:0]     w_grant_id;
  logic                  w_grant_valid;
  logic [RANK_LOG-1:0]   w_grant_prio;
  logic                  w_accept;
  logic [NUM_FIFO-1:0]   w_deq_sel;
  logic [NUM_FIFO-1:0]   w_deq_clr;
  logic [NUM_FIFO-1:0]   w_set;
  logic                  w_deq_hit;
  logic [NUM_FIFO-1:0]   w_in_pieo_nxt;

  assign w_elig = i_fifo_nonempty & ~r_in_pieo;

  pieo_rr_arbiter #(
    .NUM_REQ (NUM_FIFO),
    .ID_W    (ID_LOG)
  ) u_arb (
    .i_req         (w_elig),
    .i_ptr         (r_rr_ptr),
    .o_grant_id    (w_grant_id),
    .o_grant_valid (w_grant_valid)
  );

  // Rank of the winning FIFO, picked out of the flat priority bus.
  always_comb begin
    w_grant_prio = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      w_grant_prio = w_grant_prio |
        (i_fifo_priority[i*RANK_LOG +: RANK_LOG] & {RANK_LOG{w_grant_id == ID_LOG'(i)}});
    end
  end

  assign w_accept = (r_state == ST_ISSUE) && r_trig && i_pieo_ready_for_enq;

  // Ids >= NUM_FIFO match no select bit, so they always land in deq_err.
  for (genvar i = 0; i < NUM_FIFO; i++) begin : g_bits
    assign w_deq_sel[i] = i_pieo_deq_valid && (i_pieo_deq_fifo_id == ID_LOG'(i));
    assign w_set[i]     = w_accept && (r_gid == ID_LOG'(i));
  end

  assign w_deq_clr     = w_deq_sel & r_in_pieo;
  assign w_deq_hit     = |w_deq_clr;
  // Set is applied after clear so an acceptance always wins for its own bit.
  assign w_in_pieo_nxt = (r_in_pieo & ~w_deq_clr) | w_set;

  // Enqueue FSM next-state and held-element logic.
  always_comb begin
    w_state_nxt = r_state;
    w_trig_nxt  = r_trig;
    w_elem_nxt  = r_elem;
    w_gid_nxt   = r_gid;
    w_ptr_nxt   = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = ST_ISSUE;
          w_trig_nxt  = 1'b1;
          w_elem_nxt  = {TIME_LOG'(SEND_TIME), w_grant_prio, w_grant_id};
          w_gid_nxt   = w_grant_id;
        end else begin
          w_trig_nxt  = 1'b0;
        end
      end
      ST_ISSUE: begin
        // The grant is committed: element and rank stay frozen until accepted.
        if (i_pieo_ready_for_enq) begin
          w_state_nxt = ST_GAP;
          w_trig_nxt  = 1'b0;
          w_ptr_nxt   = ID_LOG'(rr_wrap_inc(int'(r_gid), NUM_FIFO));
        end else begin
          w_trig_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
        w_trig_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_trig_nxt  = 1'b0;
      end
    endcase
  end

  // State, element, pointer and occupancy registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_trig    <= 1'b0;
      r_elem    <= '0;
      r_gid     <= '0;
      r_rr_ptr  <= '0;
      r_in_pieo <= '0;
      r_deq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_trig    <= w_trig_nxt;
      r_elem    <= w_elem_nxt;
      r_gid     <= w_gid_nxt;
      r_rr_ptr  <= w_ptr_nxt;
      r_in_pieo <= w_in_pieo_nxt;
      r_deq_err <= i_pieo_deq_valid && !w_deq_hit;
    end
  end

  assign o_pieo_enq_element = r_elem;
  assign o_pieo_enq_trigger = r_trig;
  assign o_in_pieo          = r_in_pieo;
  assign o_deq_err          = r_deq_err;

endmodule

// File: tb/tb_pieo_enq_scheduler.sv
// Directed bench for pieo_enq_scheduler with a cycle-level behavioural model.
module tb_pieo_enq_scheduler;

  localparam int NF = 3;
  localparam int ST = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] ne    = 3'b000;
  logic [2:0] prio  = 3'b000;
  logic       rdy   = 1'b0;
  logic       dv    = 1'b0;
  logic [1:0] did   = 2'd0;

  logic [3:0] elem;
  logic       trig;
  logic [2:0] inp;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pieo_enq_scheduler #(
    .NUM_FIFO (3), .ID_LOG (2), .RANK_LOG (1), .TIME_LOG (1), .SEND_TIME (1)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_fifo_nonempty      (ne),
    .i_fifo_priority      (prio),
    .i_pieo_ready_for_enq (rdy),
    .i_pieo_deq_valid     (dv),
    .i_pieo_deq_fifo_id   (did),
    .o_pieo_enq_element   (elem),
    .o_pieo_enq_trigger   (trig),
    .o_in_pieo            (inp),
    .o_deq_err            (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Model state: occupancy set, outstanding request, pointer, gap flag, error.
  typedef struct packed {
    logic [2:0] inp;
    logic       trig;
    logic [3:0] elem;
    logic [1:0] g;
    logic [1:0] ptr;
    logic       gap;
    logic       err;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t step(input mdl_t s, input logic [2:0] ne_i, input logic [2:0] pr_i,
                                input logic rdy_i, input logic dv_i, input logic [1:0] id_i);
    mdl_t n = s;
    int   id = int'(id_i);
    bit   hit;
    hit   = dv_i && (id < NF) && s.inp[id];
    n.err = dv_i && !hit;
    if (hit) n.inp[id] = 1'b0;
    if (s.trig) begin
      if (rdy_i) begin
        n.inp[s.g] = 1'b1;
        n.trig     = 1'b0;
        n.ptr      = 2'((int'(s.g) + 1) % NF);
        n.gap      = 1'b1;
      end
    end else if (s.gap) begin
      n.gap = 1'b0;
    end else begin
      for (int k = 0; k < NF; k++) begin
        int j = (int'(s.ptr) + k) % NF;
        if (!n.trig && ne_i[j] && !s.inp[j]) begin
          n.trig = 1'b1;
          n.g    = 2'(j);
          n.elem = 4'(ST * 8 + int'(pr_i[j]) * 4 + j);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, ne, prio, rdy, dv, did);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("trig", 32'(trig), 32'(m.trig));
    chk("in_pieo", 32'(inp), 32'(m.inp));
    chk("deq_err", 32'(err), 32'(m.err));
    if (m.trig) chk("elem", 32'(elem), 32'(m.elem));
  end

  task automatic step_c();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ne = 3'b000; prio = 3'b000; rdy = 1'b0; dv = 1'b0; did = 2'd0;
    rst_n = 1'b0;
    step_c();
    step_c();
    rst_n = 1'b1;
  endtask

  int   n_rec;
  int   rec_id [6];
  int   rec_c  [6];
  logic prev;
  int   tcount;

  initial begin
    #1 rst_n = 1'b0;

    // Single FIFO grant, latency and no re-grant while in the PIEO.
    do_reset();
    ne = 3'b001; prio = 3'b010; rdy = 1'b1;
    @(negedge clk);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_elem", 32'(elem), 32'd0);
    chk("rst_inp", 32'(inp), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step_c(); @(negedge clk);
    chk("t1_trig", 32'(trig), 32'd1);
    chk("t1_elem", 32'(elem), 32'b1000);
    step_c(); @(negedge clk);
    chk("t1_inp", 32'(inp), 32'b001);
    chk("t1_trig_low", 32'(trig), 32'd0);
    repeat (6) step_c();
    @(negedge clk);
    chk("t1_no_regrant", 32'(trig), 32'd0);

    // All FIFOs busy, each dequeued right after acceptance.
    do_reset();
    ne = 3'b111; rdy = 1'b1;
    prev = 1'b0; n_rec = 0;
    for (int c = 1; c <= 22; c++) begin
      step_c();
      dv  = (m.inp != 3'b000);
      did = m.inp[0] ? 2'd0 : (m.inp[1] ? 2'd1 : 2'd2);
      @(negedge clk);
      if (trig && !prev && n_rec < 6) begin
        rec_id[n_rec] = int'(elem[1:0]);
        rec_c[n_rec]  = c;
        n_rec++;
      end
      prev = trig;
    end
    dv = 1'b0;
    chk("t2_count", 32'(n_rec), 32'd6);
    for (int i = 0; i < n_rec; i++) begin
      chk("t2_order", 32'(rec_id[i]), 32'(i % 3));
      if (i > 0) chk("t2_spacing", 32'(rec_c[i] - rec_c[i-1]), 32'd3);
    end

    // Back-pressure: element frozen through input changes.
    do_reset();
    ne = 3'b010; prio = 3'b010; rdy = 1'b0;
    tcount = 0;
    for (int k = 1; k <= 8; k++) begin
      step_c();
      if (k == 3) begin ne = 3'b000; prio = 3'b101; end
      if (k == 6) rdy = 1'b1;
      @(negedge clk);
      if (trig) begin
        tcount++;
        chk("t3_elem", 32'(elem), 32'b1101);
      end
    end
    chk("t3_held", 32'(tcount), 32'd6);
    chk("t3_inp", 32'(inp), 32'b010);

    // Bad dequeues: id not in the PIEO, and id out of range.
    do_reset();
    dv = 1'b1; did = 2'd1;
    step_c(); dv = 1'b0;
    @(negedge clk);
    chk("t4_err_id1", 32'(err), 32'd1);
    chk("t4_inp1", 32'(inp), 32'd0);
    step_c(); dv = 1'b1; did = 2'd3;
    @(negedge clk);
    chk("t4_err_pulse", 32'(err), 32'd0);
    step_c(); dv = 1'b0;
    @(negedge clk);
    chk("t4_err_id3", 32'(err), 32'd1);
    chk("t4_inp3", 32'(inp), 32'd0);
    step_c(); @(negedge clk);
    chk("t4_err_clear", 32'(err), 32'd0);

    // Acceptance of 2 together with dequeue of 0.
    do_reset();
    ne = 3'b001; rdy = 1'b1;
    step_c();
    step_c(); ne = 3'b100;
    step_c();
    step_c(); dv = 1'b1; did = 2'd0;
    @(negedge clk);
    chk("t5_trig", 32'(trig), 32'd1);
    chk("t5_elem", 32'(elem), 32'b1010);
    chk("t5_inp_before", 32'(inp), 32'b001);
    step_c(); dv = 1'b0;
    @(negedge clk);
    chk("t5_inp_after", 32'(inp), 32'b100);
    chk("t5_err", 32'(err), 32'd0);

    // Asynchronous reset while a grant is outstanding.
    do_reset();
    ne = 3'b001; rdy = 1'b1;
    step_c();
    step_c(); ne = 3'b010; rdy = 1'b0;
    step_c();
    step_c();
    @(negedge clk);
    chk("t6_trig", 32'(trig), 32'd1);
    chk("t6_elem", 32'(elem), 32'b1001);
    step_c();
    rst_n = 1'b0;
    #1;
    chk("t6_async_trig", 32'(trig), 32'd0);
    chk("t6_async_elem", 32'(elem), 32'd0);
    chk("t6_async_inp", 32'(inp), 32'd0);
    ne = 3'b011; prio = 3'b000; rdy = 1'b1;
    step_c();
    rst_n = 1'b1;
    step_c();
    @(negedge clk);
    chk("t6_restart_trig", 32'(trig), 32'd1);
    chk("t6_restart_elem", 32'(elem), 32'b1000);
    step_c();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
